// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl: serial-in parallel-out framer with start/abort control and a valid/ready word handoff
module sipo_frame_ctrl #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             input_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH:0]   parallel_output,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [7:0]       frame_count
);
  localparam int CW = $clog2(WIDTH + 2);
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
  state_t state, nxt;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] sh;
  logic acc, last, hs, go;
  assign sh = {sr, input_data};
  assign acc = state == SHIFT && in_valid;
  assign last = acc && cnt == CW'(WIDTH);
  assign hs = state == HOLD && out_valid && out_ready;
  assign go = state == IDLE && start;
  assign in_ready = state == SHIFT;
  assign busy = state != IDLE;
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;
  // next state: abort wins, a handshake with start held chains straight into the next frame
  always_comb begin
    nxt = state;
    nxt = abort ? IDLE : go ? SHIFT : last ? HOLD : hs ? (start ? SHIFT : IDLE) : state;
  end
  // datapath: shift register, bit counter, output word and frame counter
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sr <= '0;
      cnt <= '0;
      parallel_output <= '0;
      out_valid <= 1'b0;
      frame_count <= '0;
    end else if (abort) begin
      sr <= '0;
      cnt <= '0;
      out_valid <= 1'b0;
    end else begin
      if (go) cnt <= '0;
      if (acc) begin
        sr <= sh[WIDTH-1:0];
        cnt <= cnt + CW'(1);
      end
      if (last) begin
        parallel_output <= sh;
        out_valid <= 1'b1;
      end
      if (hs) begin
        out_valid <= 1'b0;
        frame_count <= frame_count + 8'd1;
        if (start) cnt <= '0;
      end
    end
endmodule
